// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes and
// the select/operation codes that the datapath muxes decode.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_IF   = 3'b000,
    ST_ID   = 3'b001,
    ST_EXE  = 3'b010,
    ST_MEM  = 3'b011,
    ST_WB   = 3'b100,
    ST_HALT = 3'b111
  } state_t;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b010000;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLTI  = 6'b011100;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [2:0] SRCB_REGB = 3'b000;
  localparam logic [2:0] SRCB_FOUR = 3'b001;
  localparam logic [2:0] SRCB_LS   = 3'b010;
  localparam logic [2:0] SRCB_BEQ  = 3'b011;
  localparam logic [2:0] SRCB_ZEXT = 3'b100;
  localparam logic [2:0] SRCB_ZERO = 3'b101;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_JR     = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  // One-hot instruction class; all-zero means the opcode is not recognised.
  typedef struct packed {
    logic add, sub, addiu, andi, ori, slti, sw, lw, beq, bne, j, jal, jr, halt;
  } op_t;

  function automatic logic op_legal(input op_t d);
    return |d;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Purely combinational opcode classifier feeding the controller FSM.
module mc_decode
  import mc_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] opcode,
  output op_t            op
);

  always_comb begin
    op       = '0;
    op.add   = (opcode == OPW'(OP_ADD));
    op.sub   = (opcode == OPW'(OP_SUB));
    op.addiu = (opcode == OPW'(OP_ADDIU));
    op.andi  = (opcode == OPW'(OP_ANDI));
    op.ori   = (opcode == OPW'(OP_ORI));
    op.slti  = (opcode == OPW'(OP_SLTI));
    op.sw    = (opcode == OPW'(OP_SW));
    op.lw    = (opcode == OPW'(OP_LW));
    op.beq   = (opcode == OPW'(OP_BEQ));
    op.bne   = (opcode == OPW'(OP_BNE));
    op.j     = (opcode == OPW'(OP_J));
    op.jal   = (opcode == OPW'(OP_JAL));
    op.jr    = (opcode == OPW'(OP_JR));
    op.halt  = (opcode == OPW'(OP_HALT));
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle CPU controller: IF/ID/EXE/MEM/WB/HALT FSM with Moore-plus-decode
// control outputs and a retired-instruction counter.
module mc_control
  import mc_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output logic [2:0]     state,
  output logic [2:0]     ALUSrcB,
  output logic           ALUSrcA,
  output logic [2:0]     ALUOp,
  output logic           PCWre,
  output logic           IRWre,
  output logic           RegWre,
  output logic           mRD,
  output logic           mWR,
  output logic           ExtSel,
  output logic [1:0]     PCSrc,
  output logic [1:0]     RegDst,
  output logic           DBDataSrc,
  output logic [31:0]    retired
);

  state_t state_reg, state_next;
  op_t    op;

  mc_decode #(.OPW(OPW)) u_decode (
    .opcode (opcode),
    .op     (op)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= ST_IF;
      retired   <= '0;
    end else begin
      state_reg <= state_next;
      if (PCWre) retired <= retired + 32'd1;
    end
  end

  assign state = state_reg;

  always_comb begin
    state_next = ST_IF;
    case (state_reg)
      ST_IF:   state_next = ST_ID;
      ST_ID: begin
        if (op.j || op.jal || op.jr) state_next = ST_IF;
        else if (op.halt)            state_next = ST_HALT;
        else if (op_legal(op))       state_next = ST_EXE;
        else                         state_next = ST_IF;
      end
      ST_EXE: begin
        if (op.beq || op.bne)     state_next = ST_IF;
        else if (op.lw || op.sw)  state_next = ST_MEM;
        else                      state_next = ST_WB;
      end
      ST_MEM:  state_next = op.lw ? ST_WB : ST_IF;
      ST_WB:   state_next = ST_IF;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_IF;
    endcase
  end

  // IF outputs never look at opcode: the instruction register is still loading.
  always_comb begin
    ALUSrcB   = SRCB_ZERO;
    ALUSrcA   = 1'b0;
    ALUOp     = ALU_ADD;
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    ExtSel    = 1'b0;
    PCSrc     = PC_NEXT;
    RegDst    = DST_RT;
    DBDataSrc = 1'b0;
    case (state_reg)
      ST_IF: begin
        IRWre   = 1'b1;
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_FOUR;
      end
      ST_ID: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_BEQ;
        if (op.jal) begin
          RegWre = 1'b1;
          RegDst = DST_RA;
        end
        if (op.j || op.jal || op.jr) begin
          PCWre = 1'b1;
          PCSrc = op.jr ? PC_JR : PC_JUMP;
        end
      end
      ST_EXE: begin
        if (op.add || op.sub || op.beq || op.bne)            ALUSrcB = SRCB_REGB;
        else if (op.addiu || op.andi || op.ori || op.slti)   ALUSrcB = SRCB_ZEXT;
        else if (op.lw || op.sw)                             ALUSrcB = SRCB_LS;
        ExtSel = op.addiu | op.slti | op.lw | op.sw | op.beq | op.bne;
        if (op.sub || op.beq || op.bne) ALUOp = ALU_SUB;
        else if (op.andi)               ALUOp = ALU_AND;
        else if (op.ori)                ALUOp = ALU_OR;
        else if (op.slti)               ALUOp = ALU_SLT;
        if (op.beq || op.bne) begin
          PCWre = 1'b1;
          PCSrc = ((op.beq && zero) || (op.bne && !zero)) ? PC_BRANCH : PC_NEXT;
        end
      end
      ST_MEM: begin
        mRD   = op.lw;
        mWR   = op.sw;
        PCWre = op.sw;
      end
      ST_WB: begin
        RegWre    = 1'b1;
        PCWre     = 1'b1;
        RegDst    = (op.add || op.sub) ? DST_RD : DST_RT;
        DBDataSrc = op.lw;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have parameter OPW, default 6, opcode width.
REQ-002 SHALL have port CLK  input  1  rising-edge clock.
REQ-003 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port opcode  input  OPW  opcode field of the instruction register.
REQ-005 SHALL have port zero  input  1  ALU zero flag, valid in EXE.
REQ-006 SHALL have port state  output  3  current FSM state.
REQ-007 SHALL have port ALUSrcB  output  3  B-operand select: 000 RegB_Q, 001 constant 4, 010 lsAddr, 011 beqAddr, 100 zeroExt_out, 101 zero.
REQ-008 SHALL have port ALUSrcA  output  1  A-operand select: 0 RegA_Q, 1 PC.
REQ-009 SHALL have port ALUOp  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt.
REQ-010 SHALL have ports PCWre, IRWre, RegWre, mRD, mWR, ExtSel  output  1 each  strobes / sign-extend select.
REQ-011 SHALL have ports PCSrc  output  2  (00 PC+4, 01 branch, 10 jump, 11 jr) and RegDst  output  2  (00 rt, 01 rd, 10 $31).
REQ-012 SHALL have port DBDataSrc  output  1  write-back select: 0 ALU, 1 memory.
REQ-013 SHALL have port retired  output  32  count of completed instructions.

Function
REQ-014 SHALL implement states IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=111 in a registered state register.
REQ-015 SHALL decode opcodes: add 000000, sub 000001, addiu 000010, andi 010000, ori 010010, slti 011100, sw 110000, lw 110001, beq 110100, bne 110101, j 111000, jal 111010, jr 111001, halt 111111.
REQ-016 SHALL transition IF->ID unconditionally.
REQ-017 SHALL transition ID: j/jal/jr->IF; halt->HALT; any other legal opcode->EXE; illegal opcode->IF.
REQ-018 SHALL transition EXE: beq/bne->IF; lw/sw->MEM; otherwise->WB.
REQ-019 SHALL transition MEM: lw->WB; sw->IF. WB->IF. HALT->HALT until reset.
REQ-020 SHALL derive all outputs combinationally from the registered state and opcode (Moore plus opcode decode); opcode SHALL be sampled only when state != IF.
REQ-021 In IF: IRWre=1, ALUSrcA=1, ALUSrcB=001, ALUOp=add; all other strobes 0.
REQ-022 In ID: ALUSrcA=1, ALUSrcB=011 (branch target); for jal, RegWre=1, RegDst=10; PCWre=1 for j/jal/jr with PCSrc 10/10/11.
REQ-023 In EXE: ALUSrcB = 000 for add/sub/beq/bne, 100 for addiu/andi/ori/slti, 010 for lw/sw; ExtSel=1 for addiu/slti/lw/sw/beq/bne, else 0; ALUOp = sub for beq/bne/sub.
REQ-024 In EXE for beq/bne: PCWre=1; PCSrc=01 when (beq & zero) or (bne & !zero), else 00.
REQ-025 In MEM: mRD=1 for lw, mWR=1 for sw; PCWre=1 for sw, PCSrc=00.
REQ-026 In WB: RegWre=1, PCWre=1, PCSrc=00; RegDst=01 for add/sub, 00 otherwise; DBDataSrc=1 only for lw.
REQ-027 In any state not listed for a strobe, that strobe SHALL be 0 and ALUSrcB SHALL be 101.
REQ-028 retired SHALL increment by one on each edge where PCWre=1, wrapping 0xFFFFFFFF->0; an illegal-opcode ID->IF SHALL not increment it.
REQ-029 In HALT: all strobes 0, PCWre=0, retired frozen.

Reset
REQ-030 While RST=0, state SHALL be IF and retired SHALL be 0, asynchronously, including mid-instruction; IF-state output values then apply.
REQ-031 First state transition SHALL occur on the first rising CLK after RST deasserts.

Structure
REQ-032 State encodings, opcode constants, ALUSrcB/ALUOp/PCSrc/RegDst encodings SHALL live in a shared package mc_pkg used by the datapath muxes.
REQ-033 Opcode-to-control decode SHALL be one sub-module, mc_decode (purely combinational); FSM and counter SHALL stay in mc_control.

Verification
REQ-034 Reset, then add (000000): states IF,ID,EXE,WB,IF; EXE ALUSrcB=000; WB RegWre=1, RegDst=01; retired=1.
REQ-035 lw (110001): 5 cycles IF..WB; EXE ALUSrcB=010, ExtSel=1; MEM mRD=1; WB DBDataSrc=1; sw (110000): 4 cycles, MEM mWR=1, PCWre=1.
REQ-036 beq with zero=1 -> EXE PCWre=1, PCSrc=01; bne with zero=1 -> PCSrc=00; both return to IF after 3 cycles.
REQ-037 jal (111010): ID RegWre=1, RegDst=10, PCWre=1, PCSrc=10; next state IF; opcode 101010 -> ID->IF, no strobes, retired unchanged.
REQ-038 halt (111111) -> HALT held for 20 cycles with all strobes 0; RST pulse low during EXE of ori -> state=IF, retired=0 immediately, no RegWre.
